// File: rtl/mem_arbiter_if.sv
// Bus bundles for mem_arbiter: the CPU-facing fetch/data port and the
// memory-facing single-port request channel.

interface arb_cpu_if #(
  parameter int unsigned XLEN = 32
);
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic [31:0]     if_rdata;
  logic            if_valid;
  logic            d_load;
  logic            d_store;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [XLEN-1:0] d_rdata;
  logic            d_valid;
  logic            stall;
  logic            bus_err;

  // CPU pipeline side
  modport master (
    output if_req, if_addr, d_load, d_store, d_addr, d_wdata,
    input  if_rdata, if_valid, d_rdata, d_valid, stall, bus_err
  );

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_load, d_store, d_addr, d_wdata,
    output if_rdata, if_valid, d_rdata, d_valid, stall, bus_err
  );
endinterface

interface arb_mem_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  // Arbiter side
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  // Memory side
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one variable-latency single-port memory between instruction fetch
// and data access: data first, then fetch, stalling the pipeline until done.

module mem_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic      clock,
  input  logic      reset,
  arb_cpu_if.slave  cpu,
  arb_mem_if.master mem
);

  localparam int unsigned     CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic             TO_EN    = 1'(TIMEOUT != 0);
  localparam logic [31:0]      NOP_INST = 32'h0000_0013;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_D_WAIT = 2'd1;
  localparam logic [1:0] S_I_WAIT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             d_load_q, d_load_d;
  logic             d_store_q, d_store_d;
  logic             if_req_q, if_req_d;
  logic             err_q, err_d;
  logic [XLEN-1:0]  d_addr_q, d_addr_d;
  logic [XLEN-1:0]  d_wdata_q, d_wdata_d;
  logic [XLEN-1:0]  if_addr_q, if_addr_d;
  logic [XLEN-1:0]  d_rdata_q, d_rdata_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             any_req;
  logic             timeout_hit;
  logic             access_end;

  logic             stall_c;
  logic             mem_req_c;
  logic             mem_we_c;
  logic [XLEN-1:0]  mem_addr_c;
  logic [XLEN-1:0]  mem_wdata_c;
  logic             if_valid_c;
  logic             d_valid_c;
  logic             bus_err_c;

  assign any_req     = cpu.d_load | cpu.d_store | cpu.if_req;
  // An access ends on mem_ready, or is aborted after TIMEOUT silent cycles.
  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST) && !mem.mem_ready;
  assign access_end  = mem.mem_ready | timeout_hit;

  // State and capture registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      d_load_q   <= 1'b0;
      d_store_q  <= 1'b0;
      if_req_q   <= 1'b0;
      err_q      <= 1'b0;
      d_addr_q   <= '0;
      d_wdata_q  <= '0;
      if_addr_q  <= '0;
      d_rdata_q  <= '0;
      if_rdata_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      d_load_q   <= d_load_d;
      d_store_q  <= d_store_d;
      if_req_q   <= if_req_d;
      err_q      <= err_d;
      d_addr_q   <= d_addr_d;
      d_wdata_q  <= d_wdata_d;
      if_addr_q  <= if_addr_d;
      d_rdata_q  <= d_rdata_d;
      if_rdata_q <= if_rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    d_load_d    = d_load_q;
    d_store_d   = d_store_q;
    if_req_d    = if_req_q;
    err_d       = err_q;
    d_addr_d    = d_addr_q;
    d_wdata_d   = d_wdata_q;
    if_addr_d   = if_addr_q;
    d_rdata_d   = d_rdata_q;
    if_rdata_d  = if_rdata_q;
    cnt_d       = cnt_q;
    stall_c     = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    if_valid_c  = 1'b0;
    d_valid_c   = 1'b0;
    bus_err_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Stall is gated by reset so every output reads 0 while in reset.
        stall_c = any_req & reset;
        cnt_d   = '0;
        if (any_req) begin
          d_load_d  = cpu.d_load;
          d_store_d = cpu.d_store;
          d_addr_d  = cpu.d_addr;
          d_wdata_d = cpu.d_wdata;
          if_req_d  = cpu.if_req;
          if_addr_d = cpu.if_addr;
          state_d   = (cpu.d_load | cpu.d_store) ? S_D_WAIT : S_I_WAIT;
        end
      end

      S_D_WAIT: begin
        stall_c     = 1'b1;
        mem_req_c   = 1'b1;
        mem_we_c    = d_store_q;
        mem_addr_c  = d_addr_q;
        mem_wdata_c = d_wdata_q;
        cnt_d       = cnt_q + CNT_W'(1);
        if (access_end) begin
          cnt_d = '0;
          err_d = err_q | timeout_hit;
          // Load+store together is a store: d_rdata is left alone.
          if (d_load_q && !d_store_q) begin
            d_rdata_d = mem.mem_ready ? mem.mem_rdata : '0;
          end
          state_d = if_req_q ? S_I_WAIT : S_DONE;
        end
      end

      S_I_WAIT: begin
        stall_c    = 1'b1;
        mem_req_c  = 1'b1;
        mem_addr_c = if_addr_q;
        cnt_d      = cnt_q + CNT_W'(1);
        if (access_end) begin
          cnt_d      = '0;
          err_d      = err_q | timeout_hit;
          if_rdata_d = mem.mem_ready ? mem.mem_rdata[31:0] : NOP_INST;
          state_d    = S_DONE;
        end
      end

      S_DONE: begin
        if_valid_c = if_req_q;
        d_valid_c  = d_load_q | d_store_q;
        bus_err_c  = err_q;
        d_load_d   = 1'b0;
        d_store_d  = 1'b0;
        if_req_d   = 1'b0;
        err_d      = 1'b0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cpu.stall     = stall_c;
  assign cpu.if_valid  = if_valid_c;
  assign cpu.d_valid   = d_valid_c;
  assign cpu.bus_err   = bus_err_c;
  assign cpu.if_rdata  = if_rdata_q;
  assign cpu.d_rdata   = d_rdata_q;
  assign mem.mem_req   = mem_req_c;
  assign mem.mem_we    = mem_we_c;
  assign mem.mem_addr  = mem_addr_c;
  assign mem.mem_wdata = mem_wdata_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written
// sequences for timeout, reset mid-access and inputs changing while busy.

module tb_mem_arbiter;

  logic clock;
  logic reset;

  arb_cpu_if #(.XLEN(32)) cpu ();
  arb_mem_if #(.XLEN(32)) mem ();

  mem_arbiter #(.XLEN(32), .TIMEOUT(4)) dut (
    .clock (clock),
    .reset (reset),
    .cpu   (cpu.slave),
    .mem   (mem.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_load;
    logic        d_store;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_stall;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_ifv;
    logic [31:0] e_ifrd;
    logic        e_dv;
    logic [31:0] e_drd;
    logic        e_err;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(
    input logic rst_n, input logic if_req, input logic [31:0] if_addr,
    input logic d_load, input logic d_store, input logic [31:0] d_addr,
    input logic [31:0] d_wdata, input logic rdy, input logic [31:0] rdata,
    input logic e_stall, input logic e_req, input logic e_we,
    input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic e_ifv,
    input logic [31:0] e_ifrd, input logic e_dv, input logic [31:0] e_drd,
    input logic e_err);
    vec_t v;
    v.rst_n = rst_n;   v.if_req = if_req;   v.if_addr = if_addr;
    v.d_load = d_load; v.d_store = d_store; v.d_addr = d_addr;
    v.d_wdata = d_wdata; v.rdy = rdy;       v.rdata = rdata;
    v.e_stall = e_stall; v.e_req = e_req;   v.e_we = e_we;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_ifv = e_ifv;
    v.e_ifrd = e_ifrd; v.e_dv = e_dv;       v.e_drd = e_drd;
    v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_reqs();
    cpu.if_req  = 1'b0;
    cpu.if_addr = '0;
    cpu.d_load  = 1'b0;
    cpu.d_store = 1'b0;
    cpu.d_addr  = '0;
    cpu.d_wdata = '0;
  endtask

  // Called right after a negedge at which requests were driven. Acts as a
  // memory answering after 'lat' silent wait cycles (lat<0: never) and
  // returns at negedge+1 of the DONE cycle.
  task automatic run_txn(input int lat, input logic [31:0] rdata,
                         output int req_cycles, output logic done);
    int wc;
    wc = 0;
    req_cycles = 0;
    done = 1'b0;
    #1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (cpu.if_valid || cpu.d_valid) begin
        done = 1'b1;
      end else begin
        if (mem.mem_req) begin
          req_cycles++;
          mem.mem_ready = (lat >= 0) && (wc == lat);
          mem.mem_rdata = rdata;
          wc = mem.mem_ready ? 0 : wc + 1;
        end else begin
          mem.mem_ready = 1'b0;
        end
        @(negedge clock);
        clear_reqs();
        mem.mem_ready = 1'b0;
        #1;
      end
    end
    chk("txn_completes", 32'(done), 32'd1);
  endtask

  initial begin
    int   rc;
    logic dn;

    reset = 1'b0;
    clear_reqs();
    mem.mem_ready = 1'b0;
    mem.mem_rdata = '0;

    // rst, ifreq, ifaddr, dld, dst, daddr, dwdata, rdy, rdata | stall, req, we, addr, wdata, ifv, ifrd, dv, drd, err
    vecs[0]  = mk(0, 1, 32'h100, 1, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 32'h0,        0);
    vecs[1]  = mk(1, 1, 32'h100, 0, 0, 32'h0,    32'h0,        0, 32'h0,        1, 0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 32'h0,        0);
    vecs[2]  = mk(1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 32'h0,        1, 1, 0, 32'h100,  32'h0,        0, 32'h0,        0, 32'h0,        0);
    vecs[3]  = mk(1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        1, 32'h00500093, 1, 1, 0, 32'h100,  32'h0,        0, 32'h0,        0, 32'h0,        0);
    vecs[4]  = mk(1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        1, 32'h00500093, 0, 32'h0,        0);
    vecs[5]  = mk(1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        0, 32'h00500093, 0, 32'h0,        0);
    vecs[6]  = mk(1, 1, 32'h104, 1, 0, 32'h2000, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,    32'h0,        0, 32'h00500093, 0, 32'h0,        0);
    vecs[7]  = mk(1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        1, 32'hDEADBEEF, 1, 1, 0, 32'h2000, 32'h0,        0, 32'h00500093, 0, 32'h0,        0);
    vecs[8]  = mk(1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        1, 32'h00000013, 1, 1, 0, 32'h104,  32'h0,        0, 32'h00500093, 0, 32'hDEADBEEF, 0);
    vecs[9]  = mk(1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        1, 32'h00000013, 1, 32'hDEADBEEF, 0);
    vecs[10] = mk(1, 0, 32'h0,   0, 1, 32'h2004, 32'h12345678, 0, 32'h0,        1, 0, 0, 32'h0,    32'h0,        0, 32'h00000013, 0, 32'hDEADBEEF, 0);
    vecs[11] = mk(1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        1, 32'hCAFEF00D, 1, 1, 1, 32'h2004, 32'h12345678, 0, 32'h00000013, 0, 32'hDEADBEEF, 0);
    vecs[12] = mk(1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        0, 32'h00000013, 1, 32'hDEADBEEF, 0);
    vecs[13] = mk(1, 0, 32'h0,   1, 1, 32'h3000, 32'hA5A5A5A5, 0, 32'h0,        1, 0, 0, 32'h0,    32'h0,        0, 32'h00000013, 0, 32'hDEADBEEF, 0);
    vecs[14] = mk(1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        1, 32'h11111111, 1, 1, 1, 32'h3000, 32'hA5A5A5A5, 0, 32'h00000013, 0, 32'hDEADBEEF, 0);
    vecs[15] = mk(1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        0, 32'h00000013, 1, 32'hDEADBEEF, 0);
    vecs[16] = mk(1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        1, 32'h77777777, 0, 0, 0, 32'h0,    32'h0,        0, 32'h00000013, 0, 32'hDEADBEEF, 0);
    vecs[17] = mk(1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        0, 32'h00000013, 0, 32'hDEADBEEF, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      reset         = vecs[i].rst_n;
      cpu.if_req    = vecs[i].if_req;
      cpu.if_addr   = vecs[i].if_addr;
      cpu.d_load    = vecs[i].d_load;
      cpu.d_store   = vecs[i].d_store;
      cpu.d_addr    = vecs[i].d_addr;
      cpu.d_wdata   = vecs[i].d_wdata;
      mem.mem_ready = vecs[i].rdy;
      mem.mem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d.stall", i),     32'(cpu.stall),    32'(vecs[i].e_stall));
      chk($sformatf("v%0d.mem_req", i),   32'(mem.mem_req),  32'(vecs[i].e_req));
      chk($sformatf("v%0d.mem_we", i),    32'(mem.mem_we),   32'(vecs[i].e_we));
      chk($sformatf("v%0d.mem_addr", i),  mem.mem_addr,      vecs[i].e_addr);
      chk($sformatf("v%0d.mem_wdata", i), mem.mem_wdata,     vecs[i].e_wdata);
      chk($sformatf("v%0d.if_valid", i),  32'(cpu.if_valid), 32'(vecs[i].e_ifv));
      chk($sformatf("v%0d.if_rdata", i),  cpu.if_rdata,      vecs[i].e_ifrd);
      chk($sformatf("v%0d.d_valid", i),   32'(cpu.d_valid),  32'(vecs[i].e_dv));
      chk($sformatf("v%0d.d_rdata", i),   cpu.d_rdata,       vecs[i].e_drd);
      chk($sformatf("v%0d.bus_err", i),   32'(cpu.bus_err),  32'(vecs[i].e_err));
    end

    // Normal fetch answered in the second wait cycle
    @(negedge clock);
    clear_reqs(); mem.mem_ready = 1'b0;
    cpu.if_req = 1'b1; cpu.if_addr = 32'h300;
    run_txn(1, 32'hFFFFFFFF, rc, dn);
    chk("fetch_lat1.req_cycles", 32'(rc), 32'd2);
    chk("fetch_lat1.if_rdata", cpu.if_rdata, 32'hFFFFFFFF);
    chk("fetch_lat1.bus_err", 32'(cpu.bus_err), 32'd0);

    // Fetch that never completes: aborted after 4 request cycles
    @(negedge clock);
    cpu.if_req = 1'b1; cpu.if_addr = 32'h304;
    run_txn(-1, 32'h0, rc, dn);
    chk("fetch_to.req_cycles", 32'(rc), 32'd4);
    chk("fetch_to.bus_err", 32'(cpu.bus_err), 32'd1);
    chk("fetch_to.if_valid", 32'(cpu.if_valid), 32'd1);
    chk("fetch_to.if_rdata", cpu.if_rdata, 32'h00000013);

    // Load that never completes: d_rdata forced to 0
    @(negedge clock);
    cpu.d_load = 1'b1; cpu.d_addr = 32'h6000;
    run_txn(-1, 32'h0, rc, dn);
    chk("load_to.req_cycles", 32'(rc), 32'd4);
    chk("load_to.bus_err", 32'(cpu.bus_err), 32'd1);
    chk("load_to.d_valid", 32'(cpu.d_valid), 32'd1);
    chk("load_to.if_valid", 32'(cpu.if_valid), 32'd0);
    chk("load_to.d_rdata", cpu.d_rdata, 32'h0);

    // Load+fetch each answered in the last permitted wait cycle
    @(negedge clock);
    cpu.d_load = 1'b1; cpu.d_addr = 32'h6004;
    cpu.if_req = 1'b1; cpu.if_addr = 32'h308;
    run_txn(3, 32'h0BADF00D, rc, dn);
    chk("edge_lat3.req_cycles", 32'(rc), 32'd8);
    chk("edge_lat3.bus_err", 32'(cpu.bus_err), 32'd0);
    chk("edge_lat3.d_rdata", cpu.d_rdata, 32'h0BADF00D);
    chk("edge_lat3.if_rdata", cpu.if_rdata, 32'h0BADF00D);

    // Request inputs changing during D_WAIT have no effect
    @(negedge clock);
    cpu.d_load = 1'b1; cpu.d_addr = 32'h4000;
    cpu.if_req = 1'b1; cpu.if_addr = 32'h100;
    #1;
    chk("busy.idle_stall", 32'(cpu.stall), 32'd1);
    @(negedge clock);
    cpu.if_addr = 32'h200; cpu.d_addr = 32'h4444;
    #1;
    chk("busy.d_addr", mem.mem_addr, 32'h4000);
    mem.mem_ready = 1'b1; mem.mem_rdata = 32'h44;
    @(negedge clock);
    mem.mem_ready = 1'b1; mem.mem_rdata = 32'h55;
    #1;
    chk("busy.if_addr", mem.mem_addr, 32'h100);
    chk("busy.i_we", 32'(mem.mem_we), 32'd0);
    @(negedge clock);
    clear_reqs(); mem.mem_ready = 1'b0;
    #1;
    chk("busy.if_valid", 32'(cpu.if_valid), 32'd1);
    chk("busy.if_rdata", cpu.if_rdata, 32'h55);
    chk("busy.d_rdata", cpu.d_rdata, 32'h44);

    // Reset in the middle of a data access
    @(negedge clock);
    cpu.d_load = 1'b1; cpu.d_addr = 32'h5000;
    @(negedge clock);
    clear_reqs();
    #1;
    chk("rst.pre_mem_req", 32'(mem.mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst.mem_req", 32'(mem.mem_req), 32'd0);
    chk("rst.stall", 32'(cpu.stall), 32'd0);
    chk("rst.d_valid", 32'(cpu.d_valid), 32'd0);
    chk("rst.if_valid", 32'(cpu.if_valid), 32'd0);
    chk("rst.bus_err", 32'(cpu.bus_err), 32'd0);
    chk("rst.d_rdata", cpu.d_rdata, 32'h0);
    chk("rst.if_rdata", cpu.if_rdata, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst.rel_mem_req", 32'(mem.mem_req), 32'd0);
    chk("rst.rel_stall", 32'(cpu.stall), 32'd0);
    @(negedge clock);
    cpu.if_req = 1'b1; cpu.if_addr = 32'h400;
    run_txn(0, 32'h00000093, rc, dn);
    chk("rst.fetch_req_cycles", 32'(rc), 32'd1);
    chk("rst.fetch_if_rdata", cpu.if_rdata, 32'h00000093);
    chk("rst.fetch_d_valid", 32'(cpu.d_valid), 32'd0);
    chk("rst.fetch_bus_err", 32'(cpu.bus_err), 32'd0);

    @(negedge clock);
    clear_reqs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
